maxi_reg_responder: RTL and testbench
=====================================

// Module: maxi_reg_responder
// PURPOSE
// AXI3-style slave at the far end of the MAXIGP0 bridge. Consumes AR/AW/W requests (MaxiO, server side)
// and returns R/B responses (MaxiI, client side) from an internal 32-bit register file.
// Serves as the default user-side target below the PS7 wrapper. Supports INCR bursts up to 16 beats.
// PARAMETERS
// NREGS  16  number of 32-bit registers; power of 2, 2..256; byte window is 0 .. NREGS*4-1
// PORTS
// CLK         in   1   clock
// nRST        in   1   synchronous active-low reset
// AR__ENA     in   1   read address valid; transfer occurs when AR__ENA && AR__RDY
// AR$addr     in   32  read byte address
// AR$id       in   12  read id
// AR$len      in   4   beats-1
// AR__RDY     out  1   read address accept
// AW__ENA     in   1   write address valid; AW$addr/AW$id/AW$len as for AR
// AW$addr     in   32  |  AW$id  in 12  |  AW$len  in 4
// AW__RDY     out  1   write address accept
// W__ENA      in   1   write data valid
// W$data      in   32  write data
// W$id        in   12  write data id
// W$last      in   1   final write beat
// W__RDY      out  1   write data accept
// R__ENA      out  1   read beat valid; beat completes when R__ENA && R__RDY
// R$data      out  32  read data
// R$id        out  12  read id
// R$last      out  1   final read beat
// R$resp      out  2   0=OKAY, 2=SLVERR
// R__RDY      in   1   sink ready for R
// B__ENA      out  1   write response valid; completes when B__ENA && B__RDY
// B$id        out  12  write id  |  B$resp  out 2   0=OKAY, 2=SLVERR
// B__RDY      in   1   sink ready for B
// BEHAVIOUR
// - Reset (nRST=0 at edge): all outputs 0, regs cleared to 0, both FSMs to idle. Mid-burst reset abandons the burst; no R/B issued.
// - Index = addr[2 +: log2(NREGS)]. Beat is in range iff addr < NREGS*4; addr[1:0] ignored.
// - Read FSM, states RIDLE -> RBURST:
//   RIDLE: AR__RDY=1. On accept, latch addr/id/len, beat count=0; go to RBURST next cycle. AR__RDY=0 while in RBURST.
//   RBURST: R__ENA=1. R$data = reg[index] combinationally (0 if out of range). R$resp=0, or 2 if out of range.
//   R$last=1 when count==len. Outputs held stable while R__RDY=0.
//   On beat: addr+=4 (mod 2^32), count++. On last beat -> RIDLE; AR__RDY is 1 the following cycle.
// - Write FSM, states WIDLE -> WDATA -> WRESP:
//   WIDLE: AW__RDY=1, W__RDY=0. On AW accept, latch addr/id/len, count=0, err=0 -> WDATA.
//   WDATA: W__RDY=1. Each accepted beat writes reg[index] at that edge if in range, count<=len and W$id==latched id.
//   Otherwise the write is dropped and err=1. addr+=4 per beat.
//   Burst ends only on W$last. err=1 if W$last arrives with count!=len. Beats with count>len are dropped. -> WRESP.
//   WRESP: B__ENA=1, B$id=latched id, B$resp = err ? 2 : 0. Hold until B__RDY; then -> WIDLE.
// - Latencies: AR accept at cycle n -> first R__ENA at n+1. Final W beat at n -> B__ENA at n+1.
//   Minimum turnaround is 1 idle cycle per burst.
// - Read and write FSMs are independent and may run concurrently. A register written at edge n is visible to
//   R$data from cycle n+1; a read beat in the same cycle as the write returns the old value.
// - Only INCR bursts; no wrap/fixed burst types; no outstanding-transaction queue (one read, one write in flight).
// TESTING
// 1. AW addr=0x8 len=3 id=0x05A, W data 1,2,3,4 (last on 4th) -> regs[2..5]=1..4; B$id=0x05A, B$resp=0 one cycle after last W.
// 2. AR addr=0x8 len=3 id=0x123, R__RDY=1 -> R$data 1,2,3,4 on consecutive cycles, R$last only on 4th, R$resp=0, R$id=0x123.
// 3. NREGS=16, AR addr=0x3C len=1 -> beat0 data=reg[15] resp=0; beat1 (0x40) data=0 resp=2, last=1.
// 4. During test-2 burst hold R__RDY=0 for 3 cycles on beat1 -> R__ENA, R$data=2, R$last=0 stable; burst resumes.
// 5. AW len=1 id=7, W beats with W$id=7 then W$id=8 last -> only first written; B$resp=2. Early last (len=3, last on beat 2) -> B$resp=2.
// 6. Drop nRST mid read burst and mid WDATA -> next cycle all outputs 0, regs 0; after release AR__RDY=AW__RDY=1, no stray R/B.

Source files
------------

// File: rtl/maxi_reg_responder.sv
// AXI3-style register-file slave: independent read and write burst FSMs over NREGS 32-bit registers.
// INCR bursts only; one read and one write transaction in flight at a time.
module maxi_reg_responder #(
  parameter int unsigned NREGS = 16
) (
  input  logic        CLK,
  input  logic        nRST,
  input  logic        AR__ENA,
  input  logic [31:0] AR_addr,
  input  logic [11:0] AR_id,
  input  logic [3:0]  AR_len,
  output logic        AR__RDY,
  input  logic        AW__ENA,
  input  logic [31:0] AW_addr,
  input  logic [11:0] AW_id,
  input  logic [3:0]  AW_len,
  output logic        AW__RDY,
  input  logic        W__ENA,
  input  logic [31:0] W_data,
  input  logic [11:0] W_id,
  input  logic        W_last,
  output logic        W__RDY,
  output logic        R__ENA,
  output logic [31:0] R_data,
  output logic [11:0] R_id,
  output logic        R_last,
  output logic [1:0]  R_resp,
  input  logic        R__RDY,
  output logic        B__ENA,
  output logic [11:0] B_id,
  output logic [1:0]  B_resp,
  input  logic        B__RDY
);

  localparam int unsigned IW = $clog2(NREGS);

  typedef enum logic {StRIdle, StRBurst} rstate_e;
  typedef enum logic [1:0] {StWIdle, StWData, StWResp} wstate_e;

  logic [31:0] regs [NREGS];

  rstate_e     rstate_q, rstate_d;
  logic [31:0] raddr_q, raddr_d;
  logic [11:0] rid_q, rid_d;
  logic [3:0]  rlen_q, rlen_d;
  logic [3:0]  rcnt_q, rcnt_d;

  wstate_e     wstate_q, wstate_d;
  logic [31:0] waddr_q, waddr_d;
  logic [11:0] wid_q, wid_d;
  logic [3:0]  wlen_q, wlen_d;
  logic [4:0]  wcnt_q, wcnt_d;  // one extra bit so overrun beats never wrap back into range
  logic        werr_q, werr_d;

  logic          rd_in_range, wr_in_range, wr_en;
  logic [IW-1:0] rd_idx, wr_idx;

  assign rd_in_range = (raddr_q[31:IW+2] == '0);
  assign wr_in_range = (waddr_q[31:IW+2] == '0);
  assign rd_idx      = raddr_q[2 +: IW];
  assign wr_idx      = waddr_q[2 +: IW];

  // Read FSM
  always_comb begin
    rstate_d = rstate_q;
    raddr_d  = raddr_q;
    rid_d    = rid_q;
    rlen_d   = rlen_q;
    rcnt_d   = rcnt_q;
    AR__RDY  = 1'b0;
    R__ENA   = 1'b0;
    R_data   = 32'd0;
    R_id     = 12'd0;
    R_last   = 1'b0;
    R_resp   = 2'd0;
    unique case (rstate_q)
      StRIdle: begin
        AR__RDY = nRST;
        if (AR__ENA) begin
          raddr_d  = AR_addr;
          rid_d    = AR_id;
          rlen_d   = AR_len;
          rcnt_d   = 4'd0;
          rstate_d = StRBurst;
        end
      end
      StRBurst: begin
        R__ENA = 1'b1;
        R_data = rd_in_range ? regs[rd_idx] : 32'd0;
        R_resp = rd_in_range ? 2'd0 : 2'd2;
        R_id   = rid_q;
        R_last = (rcnt_q == rlen_q);
        if (R__RDY) begin
          raddr_d = raddr_q + 32'd4;
          rcnt_d  = rcnt_q + 4'd1;
          if (rcnt_q == rlen_q) rstate_d = StRIdle;
        end
      end
      default: rstate_d = StRIdle;
    endcase
  end

  // Write FSM
  always_comb begin
    wstate_d = wstate_q;
    waddr_d  = waddr_q;
    wid_d    = wid_q;
    wlen_d   = wlen_q;
    wcnt_d   = wcnt_q;
    werr_d   = werr_q;
    wr_en    = 1'b0;
    AW__RDY  = 1'b0;
    W__RDY   = 1'b0;
    B__ENA   = 1'b0;
    B_id     = 12'd0;
    B_resp   = 2'd0;
    unique case (wstate_q)
      StWIdle: begin
        AW__RDY = nRST;
        if (AW__ENA) begin
          waddr_d  = AW_addr;
          wid_d    = AW_id;
          wlen_d   = AW_len;
          wcnt_d   = 5'd0;
          werr_d   = 1'b0;
          wstate_d = StWData;
        end
      end
      StWData: begin
        W__RDY = 1'b1;
        if (W__ENA) begin
          wr_en   = wr_in_range && (wcnt_q <= {1'b0, wlen_q}) && (W_id == wid_q);
          waddr_d = waddr_q + 32'd4;
          if (!wr_en) werr_d = 1'b1;
          if (wcnt_q != 5'd16) wcnt_d = wcnt_q + 5'd1;
          if (W_last) begin
            if (wcnt_q != {1'b0, wlen_q}) werr_d = 1'b1;
            wstate_d = StWResp;
          end
        end
      end
      StWResp: begin
        B__ENA = 1'b1;
        B_id   = wid_q;
        B_resp = werr_q ? 2'd2 : 2'd0;
        if (B__RDY) wstate_d = StWIdle;
      end
      default: wstate_d = StWIdle;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (!nRST) begin
      rstate_q <= StRIdle;
      raddr_q  <= 32'd0;
      rid_q    <= 12'd0;
      rlen_q   <= 4'd0;
      rcnt_q   <= 4'd0;
      wstate_q <= StWIdle;
      waddr_q  <= 32'd0;
      wid_q    <= 12'd0;
      wlen_q   <= 4'd0;
      wcnt_q   <= 5'd0;
      werr_q   <= 1'b0;
    end else begin
      rstate_q <= rstate_d;
      raddr_q  <= raddr_d;
      rid_q    <= rid_d;
      rlen_q   <= rlen_d;
      rcnt_q   <= rcnt_d;
      wstate_q <= wstate_d;
      waddr_q  <= waddr_d;
      wid_q    <= wid_d;
      wlen_q   <= wlen_d;
      wcnt_q   <= wcnt_d;
      werr_q   <= werr_d;
    end
  end

  always_ff @(posedge CLK) begin
    if (!nRST) begin
      for (int i = 0; i < NREGS; i++) regs[i] <= 32'd0;
    end else if (wr_en) begin
      regs[wr_idx] <= W_data;
    end
  end

endmodule

// File: tb/tb_maxi_reg_responder.sv
// Directed self-checking bench for maxi_reg_responder (NREGS=16).
// Inputs change 1 time unit after the rising edge; outputs are checked before the next edge.
module tb_maxi_reg_responder;

  logic        clk = 1'b0;
  logic        nrst;
  logic        ar_ena, ar_rdy, aw_ena, aw_rdy, w_ena, w_last, w_rdy;
  logic [31:0] ar_addr, aw_addr, w_data, r_data;
  logic [11:0] ar_id, aw_id, w_id, r_id, b_id;
  logic [3:0]  ar_len, aw_len;
  logic        r_ena, r_last, r_rdy, b_ena, b_rdy;
  logic [1:0]  r_resp, b_resp;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  maxi_reg_responder #(.NREGS(16)) dut (
    .CLK(clk), .nRST(nrst),
    .AR__ENA(ar_ena), .AR_addr(ar_addr), .AR_id(ar_id), .AR_len(ar_len), .AR__RDY(ar_rdy),
    .AW__ENA(aw_ena), .AW_addr(aw_addr), .AW_id(aw_id), .AW_len(aw_len), .AW__RDY(aw_rdy),
    .W__ENA(w_ena), .W_data(w_data), .W_id(w_id), .W_last(w_last), .W__RDY(w_rdy),
    .R__ENA(r_ena), .R_data(r_data), .R_id(r_id), .R_last(r_last), .R_resp(r_resp),
    .R__RDY(r_rdy),
    .B__ENA(b_ena), .B_id(b_id), .B_resp(b_resp), .B__RDY(b_rdy)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start_ar(input logic [31:0] addr, input logic [3:0] len, input logic [11:0] id);
    ar_ena = 1'b1; ar_addr = addr; ar_len = len; ar_id = id;
    tick();
    ar_ena = 1'b0;
  endtask

  task automatic start_aw(input logic [31:0] addr, input logic [3:0] len, input logic [11:0] id);
    aw_ena = 1'b1; aw_addr = addr; aw_len = len; aw_id = id;
    tick();
    aw_ena = 1'b0;
  endtask

  task automatic w_beat(input logic [31:0] data, input logic [11:0] id, input logic last);
    w_ena = 1'b1; w_data = data; w_id = id; w_last = last;
    tick();
    w_ena = 1'b0; w_last = 1'b0;
  endtask

  task automatic test_reset();
    nrst = 1'b0;
    tick(); tick();
    total++; if (ar_rdy !== 1'b0) begin bad++; $display("FAIL reset_ar_rdy got %b want 0", ar_rdy); end
    total++; if (aw_rdy !== 1'b0) begin bad++; $display("FAIL reset_aw_rdy got %b want 0", aw_rdy); end
    total++; if ({r_ena, w_rdy, b_ena} !== 3'b000) begin
      bad++; $display("FAIL reset_valids got %b want 000", {r_ena, w_rdy, b_ena}); end
    nrst = 1'b1;
    #1;
    total++; if ({ar_rdy, aw_rdy} !== 2'b11) begin
      bad++; $display("FAIL post_reset_rdy got %b want 11", {ar_rdy, aw_rdy}); end
  endtask

  task automatic test_write_basic();
    total++; if (aw_rdy !== 1'b1) begin bad++; $display("FAIL wb_aw_rdy got %b want 1", aw_rdy); end
    start_aw(32'h8, 4'd3, 12'h05A);
    total++; if ({w_rdy, aw_rdy} !== 2'b10) begin
      bad++; $display("FAIL wb_wdata_rdys got %b want 10", {w_rdy, aw_rdy}); end
    for (int i = 0; i < 4; i++) w_beat(32'(i + 1), 12'h05A, i == 3);
    total++; if (b_ena !== 1'b1) begin bad++; $display("FAIL wb_b_ena got %b want 1", b_ena); end
    total++; if (b_id !== 12'h05A) begin bad++; $display("FAIL wb_b_id got %h want 05a", b_id); end
    total++; if (b_resp !== 2'd0) begin bad++; $display("FAIL wb_b_resp got %0d want 0", b_resp); end
    b_rdy = 1'b1; tick(); b_rdy = 1'b0;
    total++; if ({b_ena, aw_rdy} !== 2'b01) begin
      bad++; $display("FAIL wb_after_b got %b want 01", {b_ena, aw_rdy}); end
  endtask

  task automatic test_read_basic();
    r_rdy = 1'b1;
    start_ar(32'h8, 4'd3, 12'h123);
    for (int i = 0; i < 4; i++) begin
      total++; if (r_ena !== 1'b1) begin bad++; $display("FAIL rb_ena beat%0d got %b want 1", i, r_ena); end
      total++; if (r_data !== 32'(i + 1)) begin
        bad++; $display("FAIL rb_data beat%0d got %h want %h", i, r_data, i + 1); end
      total++; if (r_last !== (i == 3)) begin
        bad++; $display("FAIL rb_last beat%0d got %b want %b", i, r_last, i == 3); end
      total++; if ({r_resp, r_id} !== {2'd0, 12'h123}) begin
        bad++; $display("FAIL rb_resp_id beat%0d got %0d/%h want 0/123", i, r_resp, r_id); end
      tick();
    end
    total++; if ({r_ena, ar_rdy} !== 2'b01) begin
      bad++; $display("FAIL rb_after got %b want 01", {r_ena, ar_rdy}); end
  endtask

  task automatic test_read_boundary();
    start_aw(32'h3C, 4'd0, 12'h001);
    w_beat(32'hCAFE_F00D, 12'h001, 1'b1);
    b_rdy = 1'b1; tick(); b_rdy = 1'b0;
    r_rdy = 1'b1;
    start_ar(32'h3C, 4'd1, 12'h010);
    total++; if ({r_data, r_resp, r_last} !== {32'hCAFE_F00D, 2'd0, 1'b0}) begin
      bad++; $display("FAIL bnd_beat0 got %h/%0d/%b want cafef00d/0/0", r_data, r_resp, r_last); end
    tick();
    total++; if ({r_ena, r_data, r_resp, r_last} !== {1'b1, 32'd0, 2'd2, 1'b1}) begin
      bad++; $display("FAIL bnd_beat1 got %b/%h/%0d/%b want 1/0/2/1", r_ena, r_data, r_resp, r_last); end
    tick();
    total++; if (r_ena !== 1'b0) begin bad++; $display("FAIL bnd_done got %b want 0", r_ena); end
  endtask

  task automatic test_read_stall();
    r_rdy = 1'b1;
    start_ar(32'h8, 4'd3, 12'h123);
    total++; if (r_data !== 32'd1) begin bad++; $display("FAIL st_beat0 got %h want 1", r_data); end
    tick();
    r_rdy = 1'b0;
    for (int c = 0; c < 3; c++) begin
      total++; if ({r_ena, r_data, r_last} !== {1'b1, 32'd2, 1'b0}) begin
        bad++; $display("FAIL st_hold cyc%0d got %b/%h/%b want 1/2/0", c, r_ena, r_data, r_last); end
      tick();
    end
    r_rdy = 1'b1;
    for (int i = 1; i < 4; i++) begin
      total++; if ({r_data, r_last} !== {32'(i + 1), i == 3}) begin
        bad++; $display("FAIL st_resume beat%0d got %h/%b want %h/%b", i, r_data, r_last, i + 1, i == 3); end
      tick();
    end
    total++; if (r_ena !== 1'b0) begin bad++; $display("FAIL st_done got %b want 0", r_ena); end
  endtask

  task automatic test_write_errors();
    start_aw(32'h10, 4'd1, 12'h007);
    w_beat(32'h0000_AAAA, 12'h007, 1'b0);
    w_beat(32'h0000_BBBB, 12'h008, 1'b1);
    total++; if ({b_ena, b_id, b_resp} !== {1'b1, 12'h007, 2'd2}) begin
      bad++; $display("FAIL we_id_b got %b/%h/%0d want 1/007/2", b_ena, b_id, b_resp); end
    b_rdy = 1'b1; tick(); b_rdy = 1'b0;
    start_aw(32'h30, 4'd3, 12'h009);
    w_beat(32'h11, 12'h009, 1'b0);
    w_beat(32'h22, 12'h009, 1'b1);
    total++; if ({b_ena, b_id, b_resp} !== {1'b1, 12'h009, 2'd2}) begin
      bad++; $display("FAIL we_early_b got %b/%h/%0d want 1/009/2", b_ena, b_id, b_resp); end
    b_rdy = 1'b1; tick(); b_rdy = 1'b0;
    r_rdy = 1'b1;
    start_ar(32'h10, 4'd1, 12'h0);
    total++; if (r_data !== 32'h0000_AAAA) begin bad++; $display("FAIL we_reg4 got %h want aaaa", r_data); end
    tick();
    total++; if (r_data !== 32'd4) begin bad++; $display("FAIL we_reg5_kept got %h want 4", r_data); end
    tick();
    start_ar(32'h30, 4'd1, 12'h0);
    total++; if (r_data !== 32'h11) begin bad++; $display("FAIL we_reg12 got %h want 11", r_data); end
    tick();
    total++; if (r_data !== 32'h22) begin bad++; $display("FAIL we_reg13 got %h want 22", r_data); end
    tick();
  endtask

  task automatic test_back_to_back();
    // Read and write of reg0 in flight together: same-cycle read returns the old value.
    r_rdy = 1'b1;
    ar_ena = 1'b1; ar_addr = 32'h0; ar_len = 4'd0; ar_id = 12'h0AB;
    aw_ena = 1'b1; aw_addr = 32'h0; aw_len = 4'd0; aw_id = 12'h0CD;
    tick();
    ar_ena = 1'b0; aw_ena = 1'b0;
    total++; if ({r_ena, w_rdy} !== 2'b11) begin
      bad++; $display("FAIL bb_both_active got %b want 11", {r_ena, w_rdy}); end
    total++; if ({r_data, r_last} !== {32'd0, 1'b1}) begin
      bad++; $display("FAIL bb_old_value got %h/%b want 0/1", r_data, r_last); end
    w_beat(32'h77, 12'h0CD, 1'b1);
    total++; if ({r_ena, b_ena, b_id} !== {1'b0, 1'b1, 12'h0CD}) begin
      bad++; $display("FAIL bb_after got %b/%b/%h want 0/1/0cd", r_ena, b_ena, b_id); end
    b_rdy = 1'b1; tick(); b_rdy = 1'b0;
    start_ar(32'h0, 4'd0, 12'h0AB);
    total++; if (r_data !== 32'h77) begin bad++; $display("FAIL bb_new_value got %h want 77", r_data); end
    tick();
  endtask

  task automatic test_mid_reset();
    r_rdy = 1'b0;
    ar_ena = 1'b1; ar_addr = 32'h8; ar_len = 4'd3; ar_id = 12'h321;
    aw_ena = 1'b1; aw_addr = 32'h0; aw_len = 4'd3; aw_id = 12'h003;
    tick();
    ar_ena = 1'b0; aw_ena = 1'b0;
    w_beat(32'h55, 12'h003, 1'b0);
    total++; if ({r_ena, w_rdy} !== 2'b11) begin
      bad++; $display("FAIL mr_busy got %b want 11", {r_ena, w_rdy}); end
    nrst = 1'b0;
    tick();
    total++; if ({ar_rdy, aw_rdy, w_rdy, r_ena, r_last, b_ena} !== 6'd0) begin
      bad++; $display("FAIL mr_ctrl_zero got %b want 000000", {ar_rdy, aw_rdy, w_rdy, r_ena, r_last, b_ena}); end
    total++; if ({r_data, r_id, r_resp, b_id, b_resp} !== 60'd0) begin
      bad++; $display("FAIL mr_data_zero got %h want 0", {r_data, r_id, r_resp, b_id, b_resp}); end
    nrst = 1'b1;
    #1;
    total++; if ({ar_rdy, aw_rdy} !== 2'b11) begin
      bad++; $display("FAIL mr_release_rdy got %b want 11", {ar_rdy, aw_rdy}); end
    for (int c = 0; c < 3; c++) begin
      tick();
      total++; if ({r_ena, b_ena} !== 2'b00) begin
        bad++; $display("FAIL mr_stray cyc%0d got %b want 00", c, {r_ena, b_ena}); end
    end
    r_rdy = 1'b1;
    start_ar(32'h0, 4'd3, 12'h0);
    for (int i = 0; i < 4; i++) begin
      total++; if (r_data !== 32'd0) begin
        bad++; $display("FAIL mr_regs_cleared beat%0d got %h want 0", i, r_data); end
      tick();
    end
  endtask

  initial begin
    nrst = 1'b0;
    ar_ena = 1'b0; ar_addr = '0; ar_id = '0; ar_len = '0;
    aw_ena = 1'b0; aw_addr = '0; aw_id = '0; aw_len = '0;
    w_ena = 1'b0; w_data = '0; w_id = '0; w_last = 1'b0;
    r_rdy = 1'b0; b_rdy = 1'b0;
    test_reset();
    test_write_basic();
    test_read_basic();
    test_read_boundary();
    test_read_stall();
    test_write_errors();
    test_back_to_back();
    test_mid_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
